// File: rtl/bisr_output_streamer_pkg.sv
// Shared types and sizing helpers for the BISR output streamer.
package bisr_output_streamer_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_ROWS      = 4;
  localparam int unsigned DEF_COLS      = 4;
  localparam int unsigned DEF_WORD_SIZE = 16;
  localparam int unsigned NUM_ELEMS     = DEF_ROWS * DEF_COLS;
  localparam int unsigned IDX_W         = width_of(NUM_ELEMS);
  localparam int unsigned ROW_W         = width_of(DEF_ROWS);
  localparam int unsigned COL_W         = width_of(DEF_COLS);

endpackage

// File: rtl/bisr_output_streamer_if.sv
// Valid/ready word stream carrying one matrix element with row/col tags.
interface bisr_output_streamer_if
  import bisr_output_streamer_pkg::*;
#(
  parameter int unsigned WORD_W   = DEF_WORD_SIZE,
  parameter int unsigned ROW_BITS = ROW_W,
  parameter int unsigned COL_BITS = COL_W
) ();

  logic [WORD_W-1:0]   out_data;
  logic                out_valid;
  logic                out_ready;
  logic [ROW_BITS-1:0] out_row;
  logic [COL_BITS-1:0] out_col;
  logic                out_last;

  modport master (
    output out_data, out_valid, out_row, out_col, out_last,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_row, out_col, out_last,
    output out_ready
  );

endinterface

// File: rtl/bisr_output_streamer_mux.sv
// Combinational selector returning element (row, col) of a flat row-major image.
module matrix_word_mux
  import bisr_output_streamer_pkg::*;
#(
  parameter int unsigned ROWS      = DEF_ROWS,
  parameter int unsigned COLS      = DEF_COLS,
  parameter int unsigned WORD_SIZE = DEF_WORD_SIZE,
  parameter int unsigned ROW_BITS  = width_of(ROWS),
  parameter int unsigned COL_BITS  = width_of(COLS)
) (
  input  logic [ROWS*COLS*WORD_SIZE-1:0] matrix_i,
  input  logic [ROW_BITS-1:0]            row_i,
  input  logic [COL_BITS-1:0]            col_i,
  output logic [WORD_SIZE-1:0]           word_o
);

  always_comb begin
    word_o = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        if (row_i == ROW_BITS'(r) && col_i == COL_BITS'(c)) begin
          word_o = matrix_i[(r*COLS+c)*WORD_SIZE +: WORD_SIZE];
        end
      end
    end
  end

endmodule

// File: rtl/bisr_output_streamer.sv
// Captures the systolic result image on matrix_rdy rising and streams it row-major,
// with a one-deep pending image and a sticky overrun flag for dropped matrices.
module bisr_output_streamer
  import bisr_output_streamer_pkg::*;
#(
  parameter int unsigned ROWS      = DEF_ROWS,
  parameter int unsigned COLS      = DEF_COLS,
  parameter int unsigned WORD_SIZE = DEF_WORD_SIZE
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           matrix_rdy_i,
  input  logic [ROWS*COLS*WORD_SIZE-1:0] output_matrix_i,
  input  logic                           clear_overrun_i,
  output logic                           busy_o,
  output logic                           overrun_o,
  bisr_output_streamer_if.master         out_if
);

  localparam int unsigned ELEMS    = ROWS * COLS;
  localparam int unsigned IMG_W    = ELEMS * WORD_SIZE;
  localparam int unsigned IDX_BITS = width_of(ELEMS);
  localparam int unsigned ROW_BITS = width_of(ROWS);
  localparam int unsigned COL_BITS = width_of(COLS);

  state_t               state_q, state_d;
  logic                 mrdy_q;
  logic [IMG_W-1:0]     active_q, active_d, pending_q, pending_d;
  logic                 pend_q, pend_d;
  logic [IDX_BITS-1:0]  idx_q, idx_d;
  logic [ROW_BITS-1:0]  row_q, row_d;
  logic [COL_BITS-1:0]  col_q, col_d;
  logic                 overrun_q, overrun_d;
  logic                 cap, fire, at_last, eos, drop;
  logic [WORD_SIZE-1:0] word;

  assign cap     = matrix_rdy_i & ~mrdy_q;
  assign fire    = (state_q == STREAM) & out_if.out_ready;
  assign at_last = (idx_q == IDX_BITS'(ELEMS - 1));
  assign eos     = fire & at_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cap) state_d = STREAM;
      STREAM:  if (eos && !pend_q && !cap) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_if.out_valid = (state_q == STREAM);
    out_if.out_last  = (state_q == STREAM) & at_last;
    out_if.out_row   = row_q;
    out_if.out_col   = col_q;
    out_if.out_data  = word;
    busy_o           = (state_q == STREAM) | pend_q;
    overrun_o        = overrun_q;
  end

  // A capture on the final transfer reloads active directly (or pending is promoted
  // and the new image refills pending), so back-to-back matrices stream without a bubble.
  always_comb begin
    active_d  = active_q;
    pending_d = pending_q;
    pend_d    = pend_q;
    idx_d     = idx_q;
    row_d     = row_q;
    col_d     = col_q;
    drop      = 1'b0;
    if (state_q == IDLE) begin
      if (cap) begin
        active_d = output_matrix_i;
        idx_d    = '0;
        row_d    = '0;
        col_d    = '0;
      end
    end else if (eos) begin
      idx_d = '0;
      row_d = '0;
      col_d = '0;
      if (pend_q) begin
        active_d = pending_q;
        if (cap) pending_d = output_matrix_i;
        else     pend_d    = 1'b0;
      end else if (cap) begin
        active_d = output_matrix_i;
      end
    end else begin
      if (fire) begin
        idx_d = idx_q + IDX_BITS'(1);
        if (col_q == COL_BITS'(COLS - 1)) begin
          col_d = '0;
          row_d = row_q + ROW_BITS'(1);
        end else begin
          col_d = col_q + COL_BITS'(1);
        end
      end
      if (cap) begin
        if (!pend_q) begin
          pending_d = output_matrix_i;
          pend_d    = 1'b1;
        end else begin
          drop = 1'b1;
        end
      end
    end
    overrun_d = (overrun_q & ~clear_overrun_i) | drop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mrdy_q    <= 1'b0;
      active_q  <= '0;
      pending_q <= '0;
      pend_q    <= 1'b0;
      idx_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      mrdy_q    <= matrix_rdy_i;
      active_q  <= active_d;
      pending_q <= pending_d;
      pend_q    <= pend_d;
      idx_q     <= idx_d;
      row_q     <= row_d;
      col_q     <= col_d;
      overrun_q <= overrun_d;
    end
  end

  matrix_word_mux #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .WORD_SIZE (WORD_SIZE),
    .ROW_BITS  (ROW_BITS),
    .COL_BITS  (COL_BITS)
  ) u_mux (
    .matrix_i (active_q),
    .row_i    (row_q),
    .col_i    (col_q),
    .word_o   (word)
  );

endmodule

// File: tb/tb_bisr_output_streamer.sv
// Directed bench for bisr_output_streamer: scoreboard of expected words per matrix.
module tb_bisr_output_streamer;
  import bisr_output_streamer_pkg::*;

  localparam int unsigned R = 4;
  localparam int unsigned C = 4;
  localparam int unsigned W = 16;

  logic             clk;
  logic             rst;
  logic             matrix_rdy;
  logic [R*C*W-1:0] omat;
  logic             clear_ov;
  logic             busy;
  logic             overrun;

  bisr_output_streamer_if #(.WORD_W(W), .ROW_BITS(ROW_W), .COL_BITS(COL_W)) bus ();

  bisr_output_streamer #(.ROWS(R), .COLS(C), .WORD_SIZE(W)) dut (
    .clk             (clk),
    .rst             (rst),
    .matrix_rdy_i    (matrix_rdy),
    .output_matrix_i (omat),
    .clear_overrun_i (clear_ov),
    .busy_o          (busy),
    .overrun_o       (overrun),
    .out_if          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]      data;
    logic [IDX_W-1:0] idx;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          words_seen;
  int          last_used;
  int          stop_at;
  bit          bp_mode;
  bit          hold;
  logic [15:0] h_data;
  logic [ROW_W-1:0] h_row;
  logic [COL_W-1:0] h_col;
  int          ev_at[3];
  logic [15:0] ev_base[3];
  bit          ev_push[3];
  bit          ev_done[3];
  int          clr_at;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] elem(input logic [15:0] base, input int unsigned i, input bit rc);
    return rc ? base + 16'((i / C) * 16 + (i % C)) : base + 16'(i);
  endfunction

  task automatic load(input logic [15:0] base, input bit rc, input bit push);
    exp_t e;
    for (int unsigned i = 0; i < NUM_ELEMS; i++) begin
      omat[i*W +: W] = elem(base, i, rc);
      if (push) begin
        e.data = elem(base, i, rc);
        e.idx  = IDX_W'(i);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic cycle();
    exp_t e;
    if (bp_mode) bus.out_ready = 1'($urandom_range(0, 1));
    if (hold) begin
      check("hold_valid", 32'(bus.out_valid), 1);
      check("hold_data", 32'(bus.out_data), 32'(h_data));
      check("hold_row", 32'(bus.out_row), 32'(h_row));
      check("hold_col", 32'(bus.out_col), 32'(h_col));
    end
    hold = 1'b0;
    if (bus.out_valid) begin
      if (bus.out_ready) begin
        check("word_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("data", 32'(bus.out_data), 32'(e.data));
          check("row", 32'(bus.out_row), 32'(e.idx) / C);
          check("col", 32'(bus.out_col), 32'(e.idx) % C);
          check("last", 32'(bus.out_last), 32'(e.idx == IDX_W'(NUM_ELEMS - 1)));
        end
        words_seen++;
      end else begin
        hold   = 1'b1;
        h_data = bus.out_data;
        h_row  = bus.out_row;
        h_col  = bus.out_col;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    for (int k = 0; k < 3; k++) begin
      ev_at[k]   = -1;
      ev_base[k] = '0;
      ev_push[k] = 1'b0;
      ev_done[k] = 1'b0;
    end
    clr_at     = -1;
    stop_at    = -1;
    words_seen = 0;
  endtask

  task automatic start(input logic [15:0] base, input bit rc);
    load(base, rc, 1'b1);
    matrix_rdy = 1'b1;
    cycle();
    matrix_rdy = 1'b0;
    check("latency_valid", 32'(bus.out_valid), 1);
    check("busy_streaming", 32'(busy), 1);
  endtask

  task automatic run(input int bound);
    int used = 0;
    while (exp_q.size() != 0 && used < bound && !(stop_at >= 0 && words_seen >= stop_at)) begin
      matrix_rdy = 1'b0;
      clear_ov   = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (!ev_done[k] && ev_at[k] == words_seen) begin
          load(ev_base[k], 1'b0, ev_push[k]);
          matrix_rdy = 1'b1;
          ev_done[k] = 1'b1;
        end
      end
      if (clr_at == words_seen) begin
        clear_ov = 1'b1;
        clr_at   = -1;
      end
      cycle();
      used++;
    end
    matrix_rdy = 1'b0;
    clear_ov   = 1'b0;
    last_used  = used;
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_drained"}, 32'(exp_q.size()), 0);
    check({tag, "_valid_low"}, 32'(bus.out_valid), 0);
    check({tag, "_busy_low"}, 32'(busy), 0);
  endtask

  initial begin
    rst           = 1'b1;
    matrix_rdy    = 1'b0;
    omat          = '0;
    clear_ov      = 1'b0;
    bus.out_ready = 1'b1;
    bp_mode       = 1'b0;
    hold          = 1'b0;
    clear_events();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_last", 32'(bus.out_last), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_data", 32'(bus.out_data), 0);
    check("rst_row", 32'(bus.out_row), 0);
    check("rst_col", 32'(bus.out_col), 0);
    rst = 1'b0;
    cycle();

    // Basic stream: 16 words on consecutive cycles, first one cycle after the edge.
    clear_events();
    start(16'h0100, 1'b1);
    run(100);
    check("basic_cycles", 32'(last_used), 16);
    expect_idle("basic");

    // Backpressure with pseudo-random ready.
    clear_events();
    bp_mode = 1'b1;
    start(16'h0300, 1'b0);
    run(400);
    bp_mode       = 1'b0;
    bus.out_ready = 1'b1;
    cycle();
    expect_idle("bp");

    // Held level: one capture only.
    clear_events();
    load(16'h0400, 1'b0, 1'b1);
    matrix_rdy = 1'b1;
    for (int i = 0; i < 40; i++) cycle();
    matrix_rdy = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    check("held_words", 32'(words_seen), 16);
    check("held_overrun", 32'(overrun), 0);
    expect_idle("held");

    // Pending: second matrix at word 5 follows without a gap.
    clear_events();
    ev_at[0] = 5; ev_base[0] = 16'h0200; ev_push[0] = 1'b1;
    start(16'h0100, 1'b1);
    run(100);
    check("pend_cycles", 32'(last_used), 32);
    check("pend_overrun", 32'(overrun), 0);
    expect_idle("pend");

    // Capture on the last transfer with pending occupied: no overrun, three back-to-back.
    clear_events();
    ev_at[0] = 5;  ev_base[0] = 16'h0600; ev_push[0] = 1'b1;
    ev_at[1] = 15; ev_base[1] = 16'h0700; ev_push[1] = 1'b1;
    start(16'h0100, 1'b1);
    run(150);
    check("lastcap_cycles", 32'(last_used), 48);
    check("lastcap_overrun", 32'(overrun), 0);
    expect_idle("lastcap");

    // Capture on the last transfer without pending: direct reload, no gap.
    clear_events();
    ev_at[0] = 15; ev_base[0] = 16'h0800; ev_push[0] = 1'b1;
    start(16'h0100, 1'b1);
    run(100);
    check("direct_cycles", 32'(last_used), 32);
    expect_idle("direct");

    // Overrun: third matrix dropped in the same cycle as clear_overrun -> set wins.
    clear_events();
    ev_at[0] = 3; ev_base[0] = 16'h0900; ev_push[0] = 1'b1;
    ev_at[1] = 6; ev_base[1] = 16'h0A00; ev_push[1] = 1'b0;
    clr_at   = 6;
    start(16'h0100, 1'b1);
    run(100);
    check("ovr_cycles", 32'(last_used), 32);
    check("ovr_set", 32'(overrun), 1);
    expect_idle("ovr");
    clear_ov = 1'b1;
    cycle();
    clear_ov = 1'b0;
    check("ovr_cleared", 32'(overrun), 0);

    // Reset mid-stream at word 7, then a fresh capture restarts at (0,0).
    clear_events();
    stop_at = 7;
    start(16'h0100, 1'b1);
    run(100);
    check("mid_words", 32'(words_seen), 7);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_data", 32'(bus.out_data), 0);
    exp_q.delete();
    hold = 1'b0;
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    clear_events();
    start(16'h0500, 1'b0);
    run(100);
    check("restart_cycles", 32'(last_used), 16);
    expect_idle("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
